// File: rtl/rs_station_pipe_pkg.sv
// rtl/rs_station_pipe_pkg.sv - shared widths, depth default, NO_TAG and ALU opcodes for the reservation station
package rs_station_pipe_pkg;

  localparam int RS_DEPTH_DEF = 16;
  localparam int ROB_ID_W_DEF = 4;   // RO_BUFFER_ID_TYPE
  localparam int REG_W_DEF    = 32;  // REG_TYPE
  localparam int OP_W_DEF     = 6;   // OP_TYPE
  localparam int IMM_W_DEF    = 32;  // IMM_TYPE
  localparam int NO_TAG       = 0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_NOP = 6'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT,
    OP_ADDI, OP_LUI, OP_JAL, OP_JALR, OP_BEQ, OP_BNE
  } op_e;

endpackage

// File: rtl/al_unit.sv
// rtl/al_unit.sv - combinational ALU producing result value and next PC for one execute-stage op
module al_unit
  import rs_station_pipe_pkg::*;
#(
  parameter int XLEN  = REG_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int IMM_W = IMM_W_DEF
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [XLEN-1:0]  vj_i,
  input  logic [XLEN-1:0]  vk_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [XLEN-1:0]  value_o,
  output logic [XLEN-1:0]  next_pc_o
);
  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] seq_pc;

  assign imm_x  = XLEN'(imm_i);
  assign seq_pc = pc_i + XLEN'(4);

  always_comb begin
    value_o   = '0;
    next_pc_o = seq_pc;
    case (op_i)
      OP_W'(OP_ADD):  value_o = vj_i + vk_i;
      OP_W'(OP_SUB):  value_o = vj_i - vk_i;
      OP_W'(OP_AND):  value_o = vj_i & vk_i;
      OP_W'(OP_OR):   value_o = vj_i | vk_i;
      OP_W'(OP_XOR):  value_o = vj_i ^ vk_i;
      OP_W'(OP_SLL):  value_o = vj_i << vk_i[SH_W-1:0];
      OP_W'(OP_SRL):  value_o = vj_i >> vk_i[SH_W-1:0];
      OP_W'(OP_SLT):  value_o = XLEN'($signed(vj_i) < $signed(vk_i));
      OP_W'(OP_ADDI): value_o = vj_i + imm_x;
      OP_W'(OP_LUI):  value_o = imm_x;
      OP_W'(OP_JAL): begin
        value_o   = seq_pc;
        next_pc_o = pc_i + imm_x;
      end
      OP_W'(OP_JALR): begin
        value_o   = seq_pc;
        next_pc_o = (vj_i + imm_x) & ~XLEN'(1);
      end
      OP_W'(OP_BEQ): if (vj_i == vk_i) next_pc_o = pc_i + imm_x;
      OP_W'(OP_BNE): if (vj_i != vk_i) next_pc_o = pc_i + imm_x;
      default: value_o = '0;
    endcase
  end

endmodule

// File: rtl/rs_station_pipe_select.sv
// rtl/rs_station_pipe_select.sv - rs_select: ready-entry picker, lowest index or oldest age with RS_OLDEST_FIRST_EN
module rs_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]         ready_i,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [$clog2(N)-1:0] age_i [N],
`endif
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IDX_W = $clog2(N);

`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] best;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    best    = '0;
    for (int i = 0; i < N; i++) begin
      if (ready_i[i] && (!valid_o || age_i[i] < best)) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
        best    = age_i[i];
      end
    end
  end
`else
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/rs_station_pipe.sv
// rtl/rs_station_pipe.sv - pipelined ALU reservation station: wakeup, select, execute, RSS broadcast
// RS_OLDEST_FIRST_EN: track per-entry age and dispatch the oldest ready op instead of the lowest index.
module rs_station_pipe
  import rs_station_pipe_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int XLEN     = REG_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int IMM_W    = IMM_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           flush,
  input  logic [ROB_ID_W-1:0]            dest_from_issuer,
  input  logic [OP_W-1:0]                op_from_issuer,
  input  logic [ROB_ID_W-1:0]            qj_from_issuer,
  input  logic [ROB_ID_W-1:0]            qk_from_issuer,
  input  logic [XLEN-1:0]                vj_from_issuer,
  input  logic [XLEN-1:0]                vk_from_issuer,
  input  logic [IMM_W-1:0]               imm_from_issuer,
  input  logic [XLEN-1:0]                pc_from_issuer,
  input  logic [ROB_ID_W-1:0]            dest_from_lsb_bus,
  input  logic [XLEN-1:0]                value_from_lsb_bus,
  input  logic [ROB_ID_W-1:0]            dest_from_rss_bus,
  input  logic [XLEN-1:0]                value_from_rss_bus,
  output logic [ROB_ID_W-1:0]            dest_to_rss_bus,
  output logic [XLEN-1:0]                value_to_rss_bus,
  output logic [XLEN-1:0]                next_pc_to_rss_bus,
  output logic                           is_rs_station_full,
  output logic [$clog2(RS_DEPTH+1)-1:0]  occupancy
);
  localparam int OCC_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam logic [ROB_ID_W-1:0] NO_TAG_W = ROB_ID_W'(NO_TAG);

  typedef struct packed {
    logic [ROB_ID_W-1:0] dest;
    logic [OP_W-1:0]     op;
    logic [XLEN-1:0]     vj;
    logic [XLEN-1:0]     vk;
    logic [IMM_W-1:0]    imm;
    logic [XLEN-1:0]     pc;
  } exec_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] qj;
    logic [ROB_ID_W-1:0] qk;
    exec_t               e;
  } entry_t;

  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy_q, busy_d, ready;
  exec_t               ex_q, ex_d;
  logic                ex_valid_q, ex_valid_d;
  logic [ROB_ID_W-1:0] bus_dest_q, bus_dest_d;
  logic [XLEN-1:0]     bus_value_q, bus_value_d, bus_npc_q, bus_npc_d;
  logic [XLEN-1:0]     alu_value, alu_npc;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                sel_valid, have_free, issue_ok;
  logic [IDX_W-1:0]    sel_idx, free_idx;
  entry_t              iss;
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0]    age_q [RS_DEPTH];
  logic [IDX_W-1:0]    age_d [RS_DEPTH];
`endif

  // Bus priority: own result, then external RSS, then LSB; tag 0 never matches.
  function automatic logic [ROB_ID_W+XLEN-1:0] resolve(input logic [ROB_ID_W-1:0] q,
                                                       input logic [XLEN-1:0]     v);
    resolve = {q, v};
    if (q != NO_TAG_W) begin
      if (q == bus_dest_q)             resolve = {NO_TAG_W, bus_value_q};
      else if (q == dest_from_rss_bus) resolve = {NO_TAG_W, value_from_rss_bus};
      else if (q == dest_from_lsb_bus) resolve = {NO_TAG_W, value_from_lsb_bus};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++)
      ready[i] = busy_q[i] && (ent_q[i].qj == NO_TAG_W) && (ent_q[i].qk == NO_TAG_W);
  end

  rs_select #(.N(RS_DEPTH)) u_select (
    .ready_i (ready),
`ifdef RS_OLDEST_FIRST_EN
    .age_i   (age_q),
`endif
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
  end

  assign issue_ok = (dest_from_issuer != NO_TAG_W) && have_free;

  always_comb begin
    iss.e.dest           = dest_from_issuer;
    iss.e.op             = op_from_issuer;
    iss.e.imm            = imm_from_issuer;
    iss.e.pc             = pc_from_issuer;
    {iss.qj, iss.e.vj}   = resolve(qj_from_issuer, vj_from_issuer);
    {iss.qk, iss.e.vk}   = resolve(qk_from_issuer, vk_from_issuer);
  end

  al_unit #(.XLEN(XLEN), .OP_W(OP_W), .IMM_W(IMM_W)) u_alu (
    .op_i      (ex_q.op),
    .vj_i      (ex_q.vj),
    .vk_i      (ex_q.vk),
    .imm_i     (ex_q.imm),
    .pc_i      (ex_q.pc),
    .value_o   (alu_value),
    .next_pc_o (alu_npc)
  );

  always_comb begin
    ent_d  = ent_q;
    busy_d = busy_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (busy_q[i]) begin
        {ent_d[i].qj, ent_d[i].e.vj} = resolve(ent_q[i].qj, ent_q[i].e.vj);
        {ent_d[i].qk, ent_d[i].e.vk} = resolve(ent_q[i].qk, ent_q[i].e.vk);
      end
    end
    if (sel_valid) busy_d[sel_idx] = 1'b0;
    if (issue_ok) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = iss;
    end
    occ_d       = occ_q + OCC_W'(issue_ok) - OCC_W'(sel_valid);
    ex_valid_d  = sel_valid;
    ex_d        = ent_q[sel_idx].e;
    bus_dest_d  = ex_valid_q ? ex_q.dest : NO_TAG_W;
    bus_value_d = ex_valid_q ? alu_value : '0;
    bus_npc_d   = ex_valid_q ? alu_npc   : '0;
`ifdef RS_OLDEST_FIRST_EN
    age_d = age_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel_valid && busy_q[i] && (age_q[i] > age_q[sel_idx])) age_d[i] = age_q[i] - IDX_W'(1);
    end
    if (issue_ok) age_d[free_idx] = IDX_W'(occ_q - OCC_W'(sel_valid));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      busy_q      <= '0;
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      bus_dest_q  <= '0;
      bus_value_q <= '0;
      bus_npc_q   <= '0;
      occ_q       <= '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
`endif
    end else if (rdy) begin
      ent_q       <= ent_d;
      busy_q      <= busy_d;
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      bus_dest_q  <= bus_dest_d;
      bus_value_q <= bus_value_d;
      bus_npc_q   <= bus_npc_d;
      occ_q       <= occ_d;
`ifdef RS_OLDEST_FIRST_EN
      age_q       <= age_d;
`endif
    end
  end

  assign dest_to_rss_bus    = bus_dest_q;
  assign value_to_rss_bus   = bus_value_q;
  assign next_pc_to_rss_bus = bus_npc_q;
  assign occupancy          = occ_q;
  assign is_rs_station_full = (occ_q >= OCC_W'(RS_DEPTH - 1));

  issue_into_full_a : assert property (@(posedge clk) disable iff (!rst)
    (rdy && !flush && (dest_from_issuer != NO_TAG_W)) |-> (occ_q != OCC_W'(RS_DEPTH)));

endmodule

// File: tb/tb_rs_station_pipe.sv
// tb/tb_rs_station_pipe.sv - directed self-checking bench for rs_station_pipe (RS_OLDEST_FIRST_EN aware)
module tb_rs_station_pipe;
  import rs_station_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [3:0]  dest_from_issuer, qj_from_issuer, qk_from_issuer;
  logic [5:0]  op_from_issuer;
  logic [31:0] vj_from_issuer, vk_from_issuer, imm_from_issuer, pc_from_issuer;
  logic [3:0]  dest_from_lsb_bus, dest_from_rss_bus;
  logic [31:0] value_from_lsb_bus, value_from_rss_bus;
  logic [3:0]  dest_to_rss_bus;
  logic [31:0] value_to_rss_bus, next_pc_to_rss_bus;
  logic        is_rs_station_full;
  logic [4:0]  occupancy;

  int checks = 0;
  int failures = 0;
  logic [3:0]  exp_first_dest, exp_second_dest;
  logic [31:0] exp_first_val, exp_second_val;

  always #5 clk = ~clk;

  rs_station_pipe dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dest_from_issuer(dest_from_issuer), .op_from_issuer(op_from_issuer),
    .qj_from_issuer(qj_from_issuer), .qk_from_issuer(qk_from_issuer),
    .vj_from_issuer(vj_from_issuer), .vk_from_issuer(vk_from_issuer),
    .imm_from_issuer(imm_from_issuer), .pc_from_issuer(pc_from_issuer),
    .dest_from_lsb_bus(dest_from_lsb_bus), .value_from_lsb_bus(value_from_lsb_bus),
    .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
    .dest_to_rss_bus(dest_to_rss_bus), .value_to_rss_bus(value_to_rss_bus),
    .next_pc_to_rss_bus(next_pc_to_rss_bus), .is_rs_station_full(is_rs_station_full),
    .occupancy(occupancy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] d, input logic [5:0] op, input logic [3:0] qj,
                       input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc);
    dest_from_issuer = d;
    op_from_issuer   = op;
    qj_from_issuer   = qj;
    vj_from_issuer   = vj;
    qk_from_issuer   = qk;
    vk_from_issuer   = vk;
    imm_from_issuer  = imm;
    pc_from_issuer   = pc;
    tick(1);
    dest_from_issuer = 4'd0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    dest_from_issuer = '0; op_from_issuer = '0; qj_from_issuer = '0; qk_from_issuer = '0;
    vj_from_issuer = '0; vk_from_issuer = '0; imm_from_issuer = '0; pc_from_issuer = '0;
    dest_from_lsb_bus = '0; value_from_lsb_bus = '0; dest_from_rss_bus = '0; value_from_rss_bus = '0;
    tick(3);
    rst = 1'b1;
    chk("reset_dest", 32'(dest_to_rss_bus), 32'd0);
    chk("reset_value", value_to_rss_bus, 32'd0);
    chk("reset_npc", next_pc_to_rss_bus, 32'd0);
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_full", 32'(is_rs_station_full), 32'd0);

    // ready op: bus in cycle 3, gone in cycle 4
    issue(4'd5, OP_ADD, 4'd0, 32'd3, 4'd0, 32'd4, 32'd0, 32'd0);
    chk("ready_occ_c1", 32'(occupancy), 32'd1);
    tick(1);
    chk("ready_occ_c2", 32'(occupancy), 32'd0);
    tick(1);
    chk("ready_dest_c3", 32'(dest_to_rss_bus), 32'd5);
    chk("ready_value_c3", value_to_rss_bus, 32'd7);
    tick(1);
    chk("ready_dest_c4", 32'(dest_to_rss_bus), 32'd0);
    chk("ready_value_c4", value_to_rss_bus, 32'd0);

    // dependent chain through own result bus
    issue(4'd1, OP_ADD, 4'd0, 32'd10, 4'd0, 32'd20, 32'd0, 32'd0);
    issue(4'd2, OP_ADD, 4'd1, 32'd0, 4'd0, 32'd5, 32'd0, 32'd0);
    chk("chain_occ_c2", 32'(occupancy), 32'd1);
    tick(1);
    chk("chain_a_dest", 32'(dest_to_rss_bus), 32'd1);
    chk("chain_a_value", value_to_rss_bus, 32'd30);
    tick(1);
    chk("chain_gap_dest", 32'(dest_to_rss_bus), 32'd0);
    chk("chain_b_waiting", 32'(occupancy), 32'd1);
    tick(2);
    chk("chain_b_dest", 32'(dest_to_rss_bus), 32'd2);
    chk("chain_b_value", value_to_rss_bus, 32'd35);
    tick(1);

    // issue-time bypass from the LSB bus
    dest_from_lsb_bus = 4'd7; value_from_lsb_bus = 32'h100;
    issue(4'd3, OP_ADD, 4'd7, 32'hdead, 4'd0, 32'd1, 32'd0, 32'd0);
    dest_from_lsb_bus = 4'd0; value_from_lsb_bus = 32'd0;
    tick(2);
    chk("lsb_bypass_dest", 32'(dest_to_rss_bus), 32'd3);
    chk("lsb_bypass_value", value_to_rss_bus, 32'h101);
    tick(1);

    // RSS bus wins over LSB bus when both carry the tag
    dest_from_rss_bus = 4'd6; value_from_rss_bus = 32'h50;
    dest_from_lsb_bus = 4'd6; value_from_lsb_bus = 32'h60;
    issue(4'd4, OP_ADD, 4'd0, 32'd1, 4'd6, 32'd0, 32'd0, 32'd0);
    dest_from_rss_bus = 4'd0; value_from_rss_bus = 32'd0;
    dest_from_lsb_bus = 4'd0; value_from_lsb_bus = 32'd0;
    tick(2);
    chk("bypass_prio_value", value_to_rss_bus, 32'h51);
    tick(1);

    // back-to-back dispatch, jump target
    issue(4'd8, OP_SUB, 4'd0, 32'd10, 4'd0, 32'd3, 32'd0, 32'd0);
    issue(4'd9, OP_JAL, 4'd0, 32'd0, 4'd0, 32'd0, 32'h20, 32'h1000);
    tick(1);
    chk("b2b_sub_dest", 32'(dest_to_rss_bus), 32'd8);
    chk("b2b_sub_value", value_to_rss_bus, 32'd7);
    tick(1);
    chk("b2b_jal_dest", 32'(dest_to_rss_bus), 32'd9);
    chk("b2b_jal_value", value_to_rss_bus, 32'h1004);
    chk("b2b_jal_npc", next_pc_to_rss_bus, 32'h1020);
    tick(1);

    // rdy low freezes the broadcast
    issue(4'd10, OP_OR, 4'd0, 32'hF0, 4'd0, 32'h0F, 32'd0, 32'd0);
    tick(2);
    chk("rdy_pre_value", value_to_rss_bus, 32'hFF);
    rdy = 1'b0;
    tick(1);
    chk("rdy_hold_dest", 32'(dest_to_rss_bus), 32'd10);
    tick(1);
    chk("rdy_hold_value", value_to_rss_bus, 32'hFF);
    rdy = 1'b1;
    tick(1);
    chk("rdy_release_dest", 32'(dest_to_rss_bus), 32'd0);

    // selection order: index 3 older than index 1, both woken by tag 12
`ifdef RS_OLDEST_FIRST_EN
    exp_first_dest = 4'd4; exp_first_val = 32'h21; exp_second_dest = 4'd6; exp_second_val = 32'h22;
`else
    exp_first_dest = 4'd6; exp_first_val = 32'h22; exp_second_dest = 4'd4; exp_second_val = 32'h21;
`endif
    issue(4'd1, OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    issue(4'd2, OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    issue(4'd3, OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    issue(4'd4, OP_ADD, 4'd12, 32'd0, 4'd0, 32'd1, 32'd0, 32'd0);
    dest_from_lsb_bus = 4'd10; value_from_lsb_bus = 32'd0;
    tick(1);
    dest_from_lsb_bus = 4'd0;
    tick(4);
    issue(4'd5, OP_ADD, 4'd11, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    issue(4'd6, OP_ADD, 4'd12, 32'd0, 4'd0, 32'd2, 32'd0, 32'd0);
    chk("order_occ", 32'(occupancy), 32'd3);
    dest_from_lsb_bus = 4'd12; value_from_lsb_bus = 32'h20;
    tick(1);
    dest_from_lsb_bus = 4'd0; value_from_lsb_bus = 32'd0;
    tick(2);
    chk("order_first_dest", 32'(dest_to_rss_bus), 32'(exp_first_dest));
    chk("order_first_value", value_to_rss_bus, exp_first_val);
    tick(1);
    chk("order_second_dest", 32'(dest_to_rss_bus), 32'(exp_second_dest));
    chk("order_second_value", value_to_rss_bus, exp_second_val);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("order_flush_occ", 32'(occupancy), 32'd0);

    // fill to RS_DEPTH-1 with ops blocked on tag 9
    for (int i = 0; i < 15; i++) begin
      issue(4'(i % 8 + 1), OP_ADD, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
      if (i == 13) begin
        chk("fill14_occ", 32'(occupancy), 32'd14);
        chk("fill14_full", 32'(is_rs_station_full), 32'd0);
      end
    end
    chk("fill15_occ", 32'(occupancy), 32'd15);
    chk("fill15_full", 32'(is_rs_station_full), 32'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_full", 32'(is_rs_station_full), 32'd0);
    dest_from_rss_bus = 4'd9; value_from_rss_bus = 32'd1;
    tick(1);
    dest_from_rss_bus = 4'd0; value_from_rss_bus = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("post_flush_quiet", 32'(dest_to_rss_bus), 32'd0);
    end

    // flush while an op sits in the execute stage
    issue(4'd11, OP_ADD, 4'd0, 32'd1, 4'd0, 32'd1, 32'd0, 32'd0);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_exec_dest_c3", 32'(dest_to_rss_bus), 32'd0);
    tick(1);
    chk("flush_exec_dest_c4", 32'(dest_to_rss_bus), 32'd0);
    chk("flush_exec_occ", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_station_pipe.md
Name: rs_station_pipe

Overview:
- Parametrised, pipelined successor to the ALU reservation station.
- Holds up to RS_DEPTH waiting ALU ops and wakes up operands from the LSB bus, the RSS bus and its own result bus.
- Dispatches one ready op per cycle into a registered execute stage driving al_unit, then broadcasts dest/value/next_pc on the RSS bus.
- Sits between the issuer and the ROB/RSS bus. Full throughput of 1 op/cycle, versus 1 op per 2+ cycles for a state-machine handshake.

Parameters:
- RS_DEPTH, 16, number of entries (power of 2 not required, ≥2).
- ROB_ID_W, 4, ROB tag width; tag 0 reserved as "no tag / no data".
- XLEN, 32, data/PC width.
- OP_W, 6, opcode width (matches OP_TYPE).
- IMM_W, 32, immediate width.

Ports:
- clk  in  1  clock, posedge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- rdy  in  1  global enable; 0 freezes all state.
- flush  in  1  ROB misprediction reset; synchronous clear.
- dest_from_issuer  in  ROB_ID_W  new entry's ROB tag; nonzero = issue valid.
- op_from_issuer  in  OP_W  opcode.
- qj_from_issuer / qk_from_issuer  in  ROB_ID_W  source tags, 0 = value ready.
- vj_from_issuer / vk_from_issuer  in  XLEN  source values.
- imm_from_issuer  in  IMM_W  immediate.
- pc_from_issuer  in  XLEN  instruction PC.
- dest_from_lsb_bus  in  ROB_ID_W  LSB result tag, 0 = idle.
- value_from_lsb_bus  in  XLEN  LSB result value.
- dest_from_rss_bus  in  ROB_ID_W  external RSS bus tag (other stations).
- value_from_rss_bus  in  XLEN  external RSS bus value.
- dest_to_rss_bus  out  ROB_ID_W  result tag, 0 = none.
- value_to_rss_bus  out  XLEN  result value.
- next_pc_to_rss_bus  out  XLEN  branch/jump target from al_unit.
- is_rs_station_full  out  1  pre-full indication.
- occupancy  out  clog2(RS_DEPTH+1)  current entry count.

Behaviour:
- Reset (rst=0, async) and flush (sync, rdy-independent):
  - All busy bits, tags, execute-stage valid and occupancy go to 0.
  - dest/value/next_pc_to_rss_bus go to 0.
  - Flush takes priority over issue, dispatch and wakeup in the same cycle.
- rdy=0: all registers hold, and outputs hold their last values.
- Allocation:
  - Issue (dest_from_issuer≠0) writes to the lowest-index free entry.
  - Issue-time bypass for qj/qk, in priority order: own result bus, then external RSS bus, then LSB bus. A matching nonzero tag stores value with q=0.
  - Issue while occupancy==RS_DEPTH is dropped; this is an assertion error.
- Wakeup: every cycle, each busy entry compares qj/qk against the three bus tags, matching only nonzero tags. On a match it clears q and captures the value. A woken entry is selectable the next cycle.
- Select: ready means busy && qj==0 && qk==0. Default policy picks the lowest-index ready entry. The chosen entry's busy bit clears at the select edge.
- Pipeline:
  - Cycle t: select; operands, op, imm, pc and dest are latched into the execute register.
  - Cycle t+1: al_unit evaluates combinationally on the execute register; the result is registered onto the *_to_rss_bus outputs.
  - Bus outputs are valid during t+2 for exactly one cycle, then return to 0 unless a new result follows.
  - Back-to-back dispatch every cycle is legal.
- Dependent chain: B waiting on A's tag wakes from the own-bus value in A's broadcast cycle and is selected the next cycle. Issue→bus minimum is 3 cycles for ready operands.
- Occupancy: next = cur + issue_accepted − selected, so simultaneous issue and select leaves it unchanged.
- is_rs_station_full = occupancy ≥ RS_DEPTH−1, because the issuer reacts one cycle late.
- Flush mid-execute: the in-flight execute result is discarded; no broadcast happens.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined:
  - Each entry stores age = count of older busy entries, width clog2(RS_DEPTH).
  - On issue, age is set to the surviving occupancy.
  - On select, entries with age greater than the selected entry's age decrement.
  - Select picks the ready entry with minimum age, i.e. the oldest ready op.
- Undefined: age storage is absent and select uses lowest-index priority.

Decomposition:
- Shared package/config header (config.v) holds:
  - RO_BUFFER_ID_TYPE, REG_TYPE, OP_TYPE and IMM_TYPE widths.
  - The RS_DEPTH default.
  - The NO_TAG=0 constant.
- One sub-module, rs_select: combinational picker over a ready vector (plus age vector when RS_OLDEST_FIRST_EN) returning a valid flag and an index.
- al_unit is reused unchanged.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → all bus outputs 0, occupancy 0, full 0.
- Ready op:
  - Stimulus: issue dest=5, op=ADD, vj=3, vk=4, qj=qk=0 at cycle 0.
  - Response: dest_to_rss_bus=5, value=7 in cycle 3; 0 in cycle 4.
- Chain:
  - Stimulus: issue A(dest=1, 10+20), then B(dest=2, qj=1, vk=5, ADD).
  - Response: bus shows 1/30, then B is selected the following cycle, giving 2/35 two cycles later.
- Issue-time bypass:
  - Stimulus: issue qj=7 in the same cycle dest_from_lsb_bus=7, value=0x100.
  - Response: entry is immediately ready and its result uses 0x100.
- Full/flush:
  - Stimulus: issue RS_DEPTH−1 ops all blocked on tag 9.
  - Response: full=1. Pulse flush → occupancy 0, no broadcast, and a subsequent tag-9 broadcast has no effect.
- Order (RS_OLDEST_FIRST_EN):
  - Stimulus: entries in index 3 (older) and index 1 (younger) are woken by the same tag.
  - Response: index 3 broadcasts first. Without the macro, index 1 broadcasts first.
